// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default FIFO depth and the
// feeder FSM state encoding.
package uart_pkg;

    localparam int UART_BYTE_W         = 8;
    localparam int UART_FIFO_DEPTH_DEF = 16;

    // Drain FSM states of the transmit feeder
    typedef enum logic [1:0] {
        FEED_IDLE      = 2'd0,
        FEED_WAIT_BUSY = 2'd1,
        FEED_WAIT_DONE = 2'd2
    } feed_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with occupancy count, full/empty flags and an
// optional sticky overflow flag. The head entry is read combinationally so a
// consumer can capture it on the same edge it pops. Intended for reuse on
// both the transmit and receive paths.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_FIFO_DEPTH_DEF,
    parameter int W      = UART_BYTE_W,
    parameter bit OVF_EN = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Flags come straight from the registered count, so they update one
    // cycle after the edge that moved data.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Full is judged before any same-cycle pop: a write into a full FIFO is
    // always dropped.
    assign w_push = wr_en && !w_full;
    assign w_pop  = rd_en && !w_empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; stale contents are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = w_full;
    assign empty   = w_empty;
    assign count   = r_count;

    generate
        if (OVF_EN) begin : g_ovf
            logic r_ovf;

            // Sticky overflow; a clear wins over a set in the same cycle
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ovf <= 1'b0;
                end else if (ovf_clr) begin
                    r_ovf <= 1'b0;
                end else if (wr_en && w_full) begin
                    r_ovf <= 1'b1;
                end
            end

            assign ovf = r_ovf;
        end else begin : g_no_ovf
            logic w_unused_ovf_clr;
            assign w_unused_ovf_clr = ovf_clr;
            assign ovf = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte-buffering front end for the UART transmitter: writes land in a FIFO
// and a small FSM hands them to the transmitter one frame at a time.
// Optional feature macro: UART_TX_FEEDER_OVF_EN enables the sticky overflow
// flag; without it ovf reads 0 and ovf_clr is ignored.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [UART_BYTE_W-1:0]   wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     tx_start,
    output logic [UART_BYTE_W-1:0]   tx_data,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic                     ovf,
    input  logic                     ovf_clr
);

`ifdef UART_TX_FEEDER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    feed_state_t              r_state;
    feed_state_t              w_state_next;
    logic                     w_pop;
    logic                     w_empty;
    logic [UART_BYTE_W-1:0]   w_head;
    logic                     r_tx_start;
    logic [UART_BYTE_W-1:0]   r_tx_data;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .W      (UART_BYTE_W),
        .OVF_EN (OVF_EN)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (full),
        .empty   (w_empty),
        .count   (count),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    assign empty = w_empty;

    // Drain FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FEED_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and pop decision; a frame is launched only from IDLE, and
    // only once the transmitter reports it is free.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            FEED_IDLE: begin
                if (!w_empty && !tx_busy) begin
                    w_pop        = 1'b1;
                    w_state_next = FEED_WAIT_BUSY;
                end
            end
            FEED_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_next = FEED_WAIT_DONE;
                end
            end
            FEED_WAIT_DONE: begin
                if (tx_done) begin
                    w_state_next = FEED_IDLE;
                end
            end
            default: begin
                w_state_next = FEED_IDLE;
            end
        endcase
    end

    // Start pulse lasts exactly the cycle after a pop; data holds until the next pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= w_pop;
            if (w_pop) begin
                r_tx_data <= w_head;
            end
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder with a queue-based reference model and
// a behavioural transmitter that answers tx_start with busy/done.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
`ifdef UART_TX_FEEDER_OVF_EN
    localparam int EXP_OVF = 1;
`else
    localparam int EXP_OVF = 0;
`endif

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural transmitter ----------------
    logic       stall = 1'b0;
    int         fmin  = 3;
    int         fmax  = 6;
    int         rem   = 0;
    logic [7:0] rx_q [$];
    int         gap_q [$];
    int         last_done_cyc = 0;
    logic       t_st;
    logic [7:0] t_sd;

    initial begin
        forever begin
            @(posedge clk);
            t_st = tx_start;
            t_sd = tx_data;
            #1;
            tx_done = 1'b0;
            if (reset) begin
                tx_busy = 1'b0;
                rem     = 0;
            end else if (stall) begin
                tx_busy = 1'b1;
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    tx_busy       = 1'b0;
                    tx_done       = 1'b1;
                    last_done_cyc = cyc;
                end
            end else begin
                tx_busy = 1'b0;
                if (t_st) begin
                    rx_q.push_back(t_sd);
                    gap_q.push_back((cyc - 1) - last_done_cyc);
                    tx_busy = 1'b1;
                    rem     = $urandom_range(fmax, fmin);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // The queue holds buffered bytes. A byte leaves when no frame is
    // outstanding, the queue held something before this edge and the
    // transmitter is not busy; the frame stays outstanding until tx_done.
    logic [7:0] mq [$];
    bit         m_out   = 1'b0;
    bit         m_start = 1'b0;
    bit         m_ovf   = 1'b0;
    bit         m_full_b;
    bit         m_pop;
    logic [7:0] m_data  = 8'h00;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                m_out   = 1'b0;
                m_start = 1'b0;
                m_ovf   = 1'b0;
                m_data  = 8'h00;
            end else begin
                m_full_b = (mq.size() == DEPTH);
                m_pop    = !m_out && (mq.size() != 0) && !tx_busy;
                if (EXP_OVF != 0) begin
                    if (ovf_clr) m_ovf = 1'b0;
                    else if (wr_en && m_full_b) m_ovf = 1'b1;
                end
                if (tx_done) m_out = 1'b0;
                m_start = m_pop;
                if (m_pop) begin
                    m_data = mq.pop_front();
                    m_out  = 1'b1;
                end
                if (wr_en && !m_full_b) mq.push_back(wr_data);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit en_cmp = 1'b0;
    int peak   = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (en_cmp) begin
                chk("count",    int'(count),    mq.size());
                chk("empty",    int'(empty),    int'(mq.size() == 0));
                chk("full",     int'(full),     int'(mq.size() == DEPTH));
                chk("tx_start", int'(tx_start), int'(m_start));
                chk("tx_data",  int'(tx_data),  int'(m_data));
                chk("ovf",      int'(ovf),      int'(m_ovf));
                if (int'(count) > peak) peak = int'(count);
            end
        end
    end

    task automatic wait_idle(input int limit);
        int n = 0;
        while (!(empty && !tx_busy && !m_out && !tx_start) && n < limit) begin
            @(posedge clk);
            n++;
        end
        chk("drain_within_budget", int'(n < limit), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    int dens;

    initial begin
        // reset and idle
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_data", int'(tx_data), 8'h00);
        chk("rst_ovf", int'(ovf), 0);
        en_cmp = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_no_frames", rx_q.size(), 0);
        chk("idle_tx_data", int'(tx_data), 8'h00);

        // single write, exact latency
        fmin = 6; fmax = 6;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_data = 8'hA5;
        @(posedge clk);              // edge 0
        #1 wr_en = 1'b0;
        @(negedge clk);
        chk("single_empty_after_e0", int'(empty), 0);
        chk("single_no_start_yet", int'(tx_start), 0);
        @(posedge clk);              // edge 1
        @(negedge clk);
        chk("single_tx_start", int'(tx_start), 1);
        chk("single_tx_data", int'(tx_data), 8'hA5);
        @(negedge clk);
        chk("single_start_one_cycle", int'(tx_start), 0);
        chk("single_empty_after_pop", int'(empty), 1);
        wait_idle(200);
        chk("single_frames", rx_q.size(), 1);
        chk("single_rx_byte", int'(rx_q[0]), 8'hA5);

        // burst of four
        rx_q.delete(); gap_q.delete(); peak = 0;
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        wait_idle(500);
        chk("burst_peak", peak, 3);
        chk("burst_frames", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("burst_order", int'(rx_q[i]), i + 1);
        for (int i = 1; i < 4; i++) chk("burst_gap", gap_q[i], 2);

        // fill with the transmitter stalled
        rx_q.delete();
        @(negedge clk) stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        @(negedge clk);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 16);
        chk("fill_ovf", int'(ovf), EXP_OVF);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", int'(ovf), 0);

        // full FIFO, write and pop on the same edge
        @(negedge clk) stall = 1'b0;
        fmin = 2; fmax = 5;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_data = 8'hEE;
        @(posedge clk); #1 wr_en = 1'b0;
        @(negedge clk);
        chk("full_wr_pop_count", int'(count), 15);
        chk("full_wr_pop_start", int'(tx_start), 1);
        wait_idle(1000);
        chk("wrap_frames", rx_q.size(), 16);
        for (int i = 0; i < 16; i++) chk("wrap_order", int'(rx_q[i]), 8'h10 + i);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;

        // reset while waiting for tx_done with five bytes queued
        fmin = 30; fmax = 30;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        begin
            int n = 0;
            while (!tx_busy && n < 50) begin @(posedge clk); #1; n++; end
            chk("frame_started", int'(tx_busy), 1);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_count", int'(count), 5);
        @(posedge clk); #1 reset = 1'b1;
        #1;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_full", int'(full), 0);
        chk("mid_rst_tx_start", int'(tx_start), 0);
        chk("mid_rst_tx_data", int'(tx_data), 8'h00);
        chk("mid_rst_ovf", int'(ovf), 0);
        @(posedge clk); #1 reset = 1'b0;
        rx_q.delete();
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_no_frames", rx_q.size(), 0);
        chk("post_rst_count", int'(count), 0);

        // randomized traffic
        fmin = 2; fmax = 10;
        dens = 30;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) dens = $urandom_range(90, 5);
            wr_en   = ($urandom_range(99, 0) < dens);
            wr_data = 8'($urandom);
            ovf_clr = ($urandom_range(63, 0) == 0);
            @(posedge clk); #1;
        end
        wr_en = 1'b0; ovf_clr = 1'b0;
        wait_idle(2000);
        chk("final_empty", int'(empty), 1);

        en_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
